// File: rtl/pulse_train_sequencer.sv
// rtl/pulse_train_sequencer.sv - armed delay-then-N-pulse train generator
// A rising edge on `on` latches the config and runs DELAY -> (HIGH -> LOW)* -> IDLE.
module pulse_train_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             on,
  input  logic             abort,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [CNT_W-1:0] count,
  output logic             signal,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses_left
);

  typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO = '0;

  state_t           state;
  logic             on_q;
  logic             start;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hl_q;
  logic [CNT_W-1:0] ll_q;
  logic [CNT_W-1:0] hl_eff;
  logic [CNT_W-1:0] ll_eff;

  assign start  = on & ~on_q;
  assign hl_eff = (high_len == ZERO) ? ONE : high_len;
  assign ll_eff = (low_len == ZERO) ? ONE : low_len;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      on_q        <= 1'b0;
      cnt         <= ZERO;
      hl_q        <= ZERO;
      ll_q        <= ZERO;
      signal      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulses_left <= ZERO;
    end else begin
      on_q <= on;
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state       <= IDLE;
        cnt         <= ZERO;
        signal      <= 1'b0;
        busy        <= 1'b0;
        pulses_left <= ZERO;
      end else begin
        case (state)
          IDLE: begin
            // abort sampled with the start edge suppresses the start entirely
            if (start && !abort) begin
              hl_q <= hl_eff;
              ll_q <= ll_eff;
              if (count == ZERO) begin
                done <= 1'b1;
              end else if (delay == ZERO) begin
                state       <= HIGH;
                cnt         <= hl_eff - ONE;
                signal      <= 1'b1;
                busy        <= 1'b1;
                pulses_left <= count;
              end else begin
                state       <= DELAY;
                cnt         <= delay - ONE;
                busy        <= 1'b1;
                pulses_left <= count;
              end
            end
          end
          DELAY: begin
            if (cnt == ZERO) begin
              state  <= HIGH;
              cnt    <= hl_q - ONE;
              signal <= 1'b1;
            end else begin
              cnt <= cnt - ONE;
            end
          end
          HIGH: begin
            if (cnt == ZERO) begin
              pulses_left <= pulses_left - ONE;
              signal      <= 1'b0;
              if (pulses_left == ONE) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= LOW;
                cnt   <= ll_q - ONE;
              end
            end else begin
              cnt <= cnt - ONE;
            end
          end
          LOW: begin
            if (cnt == ZERO) begin
              state  <= HIGH;
              cnt    <= hl_q - ONE;
              signal <= 1'b1;
            end else begin
              cnt <= cnt - ONE;
            end
          end
          default: begin
            state  <= IDLE;
            signal <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_train_sequencer.sv
// tb/tb_pulse_train_sequencer.sv - directed bench for pulse_train_sequencer
// Observed word is {signal, busy, done, pulses_left}, sampled 1 time unit after each rising edge.
module tb_pulse_train_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       on;
  logic       abort;
  logic [7:0] delay;
  logic [7:0] high_len;
  logic [7:0] low_len;
  logic [7:0] count;
  logic       signal;
  logic       busy;
  logic       done;
  logic [7:0] pulses_left;

  int checks   = 0;
  int failures = 0;

  pulse_train_sequencer #(.CNT_W(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .on          (on),
    .abort       (abort),
    .delay       (delay),
    .high_len    (high_len),
    .low_len     (low_len),
    .count       (count),
    .signal      (signal),
    .busy        (busy),
    .done        (done),
    .pulses_left (pulses_left)
  );

  always #5 clock = ~clock;

  wire [10:0] obs = {signal, busy, done, pulses_left};

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [10:0] basic_exp(input int e);
    logic       s;
    logic [7:0] pl;
    s  = (e >= 2 && e <= 4) || (e >= 7 && e <= 9) || (e >= 12 && e <= 14);
    pl = (e < 5) ? 8'd3 : (e < 10) ? 8'd2 : (e < 15) ? 8'd1 : 8'd0;
    return {s, (e <= 14), (e == 15), pl};
  endfunction

  task automatic start_basic;
    delay = 8'd2; high_len = 8'd3; low_len = 8'd2; count = 8'd3;
    on = 1'b1;
    tick;
    on = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; on = 1'b0; abort = 1'b0;
    delay = '0; high_len = '0; low_len = '0; count = '0;
    tick;
    checks++;
    if (obs !== 11'd0) begin
      failures++;
      $display("FAIL reset_values got=%h exp=%h", obs, 11'd0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_reset_mid_train;
    start_basic;
    tick; tick; tick;
    checks++;
    if (obs !== basic_exp(3)) begin
      failures++;
      $display("FAIL reset_pre_high got=%h exp=%h", obs, basic_exp(3));
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== 11'd0) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", obs, 11'd0);
    end
    tick;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if (obs !== 11'd0) begin
        failures++;
        $display("FAIL reset_stays_idle cyc=%0d got=%h exp=%h", i, obs, 11'd0);
      end
    end
  endtask

  task automatic test_basic;
    start_basic;
    for (int e = 0; e <= 17; e++) begin
      checks++;
      if (obs !== basic_exp(e)) begin
        failures++;
        $display("FAIL basic edge=%0d got=%h exp=%h", e, obs, basic_exp(e));
      end
      tick;
    end
  endtask

  task automatic test_zero_fields;
    logic [10:0] exp;
    delay = 8'd0; high_len = 8'd0; low_len = 8'd0; count = 8'd2;
    on = 1'b1;
    tick;
    on = 1'b0;
    for (int e = 0; e <= 4; e++) begin
      exp = {(e == 0 || e == 2), (e <= 2), (e == 3),
             (e == 0) ? 8'd2 : (e <= 2) ? 8'd1 : 8'd0};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL zero_fields edge=%0d got=%h exp=%h", e, obs, exp);
      end
      tick;
    end
    count = 8'd0; delay = 8'd3;
    on = 1'b1;
    tick;
    on = 1'b0;
    for (int e = 0; e <= 2; e++) begin
      exp = {1'b0, 1'b0, (e == 0), 8'd0};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL zero_count edge=%0d got=%h exp=%h", e, obs, exp);
      end
      tick;
    end
  endtask

  task automatic test_rearm_ignored;
    start_basic;
    for (int e = 0; e <= 20; e++) begin
      checks++;
      if (obs !== basic_exp(e)) begin
        failures++;
        $display("FAIL rearm edge=%0d got=%h exp=%h", e, obs, basic_exp(e));
      end
      if (e >= 3 && e <= 10) begin
        on = (e % 2 == 1);
        delay = 8'd0; count = 8'd9; high_len = 8'd1;
      end else if (e == 11) begin
        on = 1'b0;
        delay = 8'd2; count = 8'd3; high_len = 8'd3;
      end
      tick;
    end
  endtask

  task automatic test_abort;
    logic [10:0] exp;
    start_basic;
    for (int e = 0; e <= 18; e++) begin
      exp = (e < 8) ? basic_exp(e) : 11'd0;
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL abort edge=%0d got=%h exp=%h", e, obs, exp);
      end
      abort = (e == 7);
      tick;
    end
    abort = 1'b0;
  endtask

  task automatic test_start_with_abort;
    start_basic;
    abort = 1'b0;
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    delay = 8'd2; high_len = 8'd3; low_len = 8'd2; count = 8'd3;
    on = 1'b1; abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if (obs !== 11'd0) begin
      failures++;
      $display("FAIL start_abort_same_edge got=%h exp=%h", obs, 11'd0);
    end
    tick;
    on = 1'b0;
    checks++;
    if (obs !== 11'd0) begin
      failures++;
      $display("FAIL start_abort_no_late_start got=%h exp=%h", obs, 11'd0);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [10:0] exp;
    start_basic;
    for (int e = 1; e <= 15; e++) tick;
    checks++;
    if (obs !== basic_exp(15)) begin
      failures++;
      $display("FAIL b2b_done_cycle got=%h exp=%h", obs, basic_exp(15));
    end
    on = 1'b1;
    for (int e = 0; e <= 3; e++) begin
      tick;
      if (e == 0) on = 1'b0;
      exp = basic_exp(e);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL b2b edge=%0d got=%h exp=%h", e, obs, exp);
      end
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if (obs !== 11'd0) begin
      failures++;
      $display("FAIL b2b_cleanup got=%h exp=%h", obs, 11'd0);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_reset_mid_train;
    test_zero_fields;
    test_rearm_ignored;
    test_abort;
    test_start_with_abort;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
